lane_shift_scheduler: RTL and testbench

- Central sequencer for the vehicle-lane shift registers.
- On a level change it loads each lane's pattern in turn, waiting for each lane's loaded acknowledge.
- It then issues per-lane single-cycle shift enables at a level-dependent rate, all derived from the one system clock. No gated or muxed clocks are used.
- It sits between the level/game controller and the NUM_LANES lane registers.

---
 rtl/lane_shift_scheduler_if.sv | 37 +++
 rtl/lane_shift_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_lane_shift_scheduler.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/lane_shift_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : lane_shift_scheduler_if
//  Description : Bundle between the level/game controller, the lane
//                registers and lane_shift_scheduler.
//                master : controller / lane-register side
//                         drives NVL_IN, CN_IN, LOADED_IN
//                slave  : the scheduler
//                         drives LOAD_OUT, SHIFT_OUT, LEVEL_OUT, BUSY_OUT,
//                         ERR_OUT
//  Revision    : 1.0  initial release
// ============================================================================
interface lane_shift_scheduler_if #(
  parameter int NUM_LANES = 4
);
  logic [1:0]           LANE_SCHED_NVL_IN;     // requested level
  logic                 LANE_SCHED_CN_IN;      // level-change strobe
  logic [NUM_LANES-1:0] LANE_SCHED_LOADED_IN;  // per-lane load acknowledge
  logic [NUM_LANES-1:0] LANE_SCHED_LOAD_OUT;   // one-hot load strobe
  logic [NUM_LANES-1:0] LANE_SCHED_SHIFT_OUT;  // one-hot shift enable
  logic [1:0]           LANE_SCHED_LEVEL_OUT;  // captured level
  logic                 LANE_SCHED_BUSY_OUT;   // load sequence active
  logic                 LANE_SCHED_ERR_OUT;    // sticky load timeout

  modport master (
    output LANE_SCHED_NVL_IN, LANE_SCHED_CN_IN, LANE_SCHED_LOADED_IN,
    input  LANE_SCHED_LOAD_OUT, LANE_SCHED_SHIFT_OUT, LANE_SCHED_LEVEL_OUT,
           LANE_SCHED_BUSY_OUT, LANE_SCHED_ERR_OUT
  );

  modport slave (
    input  LANE_SCHED_NVL_IN, LANE_SCHED_CN_IN, LANE_SCHED_LOADED_IN,
    output LANE_SCHED_LOAD_OUT, LANE_SCHED_SHIFT_OUT, LANE_SCHED_LEVEL_OUT,
           LANE_SCHED_BUSY_OUT, LANE_SCHED_ERR_OUT
  );
endinterface
`default_nettype wire

// File: rtl/lane_shift_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : lane_shift_scheduler
//  Description : Central sequencer for the vehicle-lane shift registers.
//                On a level change it loads every lane in turn (one-cycle
//                one-hot LOAD strobe, then waits for that lane's ack), then
//                issues one-hot single-cycle shift enables in bursts at a
//                level-dependent rate derived from a prescaled base tick.
//                Single clock domain, no gated clocks.
//  Ports       : LANE_SCHED_CLOCK_50  in  system clock
//                LANE_SCHED_RESET     in  asynchronous, active-high reset
//                sched_bus            slave modport of lane_shift_scheduler_if
//                  NVL_IN[1:0], CN_IN, LOADED_IN[NUM_LANES]      (in)
//                  LOAD_OUT, SHIFT_OUT, LEVEL_OUT, BUSY_OUT, ERR_OUT (out)
//  Options     : `define LANE_SCHED_LOAD_TIMEOUT_EN enables the per-lane
//                acknowledge timeout (skip lane, sticky ERR_OUT). Without
//                it LOAD_WAIT waits forever and ERR_OUT is tied low.
//  Revision    : 1.0  initial release
// ============================================================================
module lane_shift_scheduler #(
  parameter int NUM_LANES      = 4,
  parameter int PRESCALE_MAX   = 2500000,
  parameter int PRESCALE_WIDTH = 22,
  parameter int PERIOD_SLOW    = 5,
  parameter int PERIOD_NORMAL  = 4,
  parameter int PERIOD_FAST    = 3,
  parameter int PERIOD_WIDTH   = 4,
  parameter int LOAD_TIMEOUT   = 255
) (
  input  wire logic              LANE_SCHED_CLOCK_50,
  input  wire logic              LANE_SCHED_RESET,
  lane_shift_scheduler_if.slave  sched_bus
);

  localparam int c_lane_w = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  localparam logic [1:0] c_st_idle      = 2'd0;
  localparam logic [1:0] c_st_load_req  = 2'd1;
  localparam logic [1:0] c_st_load_wait = 2'd2;
  localparam logic [1:0] c_st_run       = 2'd3;

  logic [1:0]                r_state;
  logic [c_lane_w-1:0]       r_lane_idx;
  logic [1:0]                r_level;
  logic [PRESCALE_WIDTH-1:0] r_prescaler;
  logic [PERIOD_WIDTH-1:0]   r_tick_cnt;
  logic [NUM_LANES-1:0]      r_load_out;
  logic [NUM_LANES-1:0]      r_shift_out;
  logic                      r_busy;

  logic [1:0]                w_state_nxt;
  logic [c_lane_w-1:0]       w_lane_nxt;
  logic [1:0]                w_level_nxt;
  logic [PERIOD_WIDTH-1:0]   w_period_m1;
  logic                      w_tick;
  logic                      w_timeout;
  logic                      w_lane_adv;

  // A lane is finished either by its own ack or by the (optional) timeout;
  // acks on other lanes are ignored by indexing with r_lane_idx.
  assign w_lane_adv = sched_bus.LANE_SCHED_LOADED_IN[r_lane_idx] | w_timeout;
  assign w_tick     = (r_prescaler == PRESCALE_WIDTH'(PRESCALE_MAX - 1));

  always_comb begin
    w_period_m1 = '0;
    case (r_level)
      2'd1:    w_period_m1 = PERIOD_WIDTH'(PERIOD_SLOW - 1);
      2'd2:    w_period_m1 = PERIOD_WIDTH'(PERIOD_NORMAL - 1);
      2'd3:    w_period_m1 = PERIOD_WIDTH'(PERIOD_FAST - 1);
      default: w_period_m1 = '0;
    endcase
  end

  // Next state. CN_IN wins over everything, in every state.
  always_comb begin
    w_state_nxt = r_state;
    w_lane_nxt  = r_lane_idx;
    w_level_nxt = r_level;
    if (sched_bus.LANE_SCHED_CN_IN) begin
      w_state_nxt = c_st_load_req;
      w_lane_nxt  = '0;
      w_level_nxt = sched_bus.LANE_SCHED_NVL_IN;
    end else begin
      case (r_state)
        c_st_load_req: w_state_nxt = c_st_load_wait;
        c_st_load_wait: begin
          if (w_lane_adv) begin
            if (r_lane_idx == c_lane_w'(NUM_LANES - 1)) begin
              w_state_nxt = c_st_run;
            end else begin
              w_lane_nxt  = r_lane_idx + c_lane_w'(1);
              w_state_nxt = c_st_load_req;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are registered from the next-state decode so LOAD_OUT/BUSY_OUT
  // line up with the cycle the FSM actually occupies the state.
  always_ff @(posedge LANE_SCHED_CLOCK_50 or posedge LANE_SCHED_RESET) begin
    if (LANE_SCHED_RESET) begin
      r_state     <= c_st_idle;
      r_lane_idx  <= '0;
      r_level     <= '0;
      r_prescaler <= '0;
      r_tick_cnt  <= '0;
      r_load_out  <= '0;
      r_shift_out <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_lane_idx <= w_lane_nxt;
      r_level    <= w_level_nxt;
      r_load_out <= (w_state_nxt == c_st_load_req) ?
                    (NUM_LANES'(1) << w_lane_nxt) : '0;
      r_busy     <= (w_state_nxt == c_st_load_req) ||
                    (w_state_nxt == c_st_load_wait);

      // Timing datapath only runs while staying in RUN; entering RUN, leaving
      // it on CN_IN, or any other state keeps it cleared, which also
      // truncates a burst in flight.
      if ((r_state != c_st_run) || (w_state_nxt != c_st_run)) begin
        r_prescaler <= '0;
        r_tick_cnt  <= '0;
        r_shift_out <= '0;
      end else begin
        // The burst walks the single set bit up one lane per cycle; bursts
        // never overlap because a burst period is >= NUM_LANES+1 cycles.
        r_shift_out <= r_shift_out << 1;
        if (w_tick) begin
          r_prescaler <= '0;
          if (r_level == 2'd0) begin
            r_tick_cnt <= '0;
          end else if (r_tick_cnt == w_period_m1) begin
            r_tick_cnt  <= '0;
            r_shift_out <= NUM_LANES'(1);
          end else begin
            r_tick_cnt <= r_tick_cnt + PERIOD_WIDTH'(1);
          end
        end else begin
          r_prescaler <= r_prescaler + PRESCALE_WIDTH'(1);
        end
      end
    end
  end

`ifdef LANE_SCHED_LOAD_TIMEOUT_EN
  localparam int c_to_w = $clog2(LOAD_TIMEOUT + 1);

  logic [c_to_w-1:0] r_to_cnt;
  logic              r_err;

  // Counter is 0 in the first LOAD_WAIT cycle, so the timeout fires in the
  // LOAD_TIMEOUT-th waiting cycle and the skip is visible one cycle later.
  assign w_timeout = (r_state == c_st_load_wait) &&
                     (r_to_cnt == c_to_w'(LOAD_TIMEOUT - 1));

  always_ff @(posedge LANE_SCHED_CLOCK_50 or posedge LANE_SCHED_RESET) begin
    if (LANE_SCHED_RESET) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      if ((r_state == c_st_load_wait) && (w_state_nxt == c_st_load_wait)) begin
        r_to_cnt <= r_to_cnt + c_to_w'(1);
      end else begin
        r_to_cnt <= '0;
      end
      if (w_timeout && !sched_bus.LANE_SCHED_CN_IN) begin
        r_err <= 1'b1;
      end
    end
  end

  assign sched_bus.LANE_SCHED_ERR_OUT = r_err;
`else
  localparam int c_unused_load_timeout = LOAD_TIMEOUT;

  assign w_timeout                    = 1'b0;
  assign sched_bus.LANE_SCHED_ERR_OUT = 1'b0;
`endif

  assign sched_bus.LANE_SCHED_LOAD_OUT  = r_load_out;
  assign sched_bus.LANE_SCHED_SHIFT_OUT = r_shift_out;
  assign sched_bus.LANE_SCHED_LEVEL_OUT = r_level;
  assign sched_bus.LANE_SCHED_BUSY_OUT  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_lane_shift_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lane_shift_scheduler
//  Description : Directed self-checking bench for lane_shift_scheduler with
//                NUM_LANES=4, PRESCALE_MAX=8, periods 4/3/2, LOAD_TIMEOUT=10.
//                Inputs change 1 time unit after each rising edge; outputs
//                are sampled at that same point (settled after the edge).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lane_shift_scheduler;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  int   rel;    // cycles since the last-lane ack (first RUN cycle = 1)

  lane_shift_scheduler_if #(.NUM_LANES(4)) u_if ();

  lane_shift_scheduler #(
    .NUM_LANES      (4),
    .PRESCALE_MAX   (8),
    .PRESCALE_WIDTH (22),
    .PERIOD_SLOW    (4),
    .PERIOD_NORMAL  (3),
    .PERIOD_FAST    (2),
    .PERIOD_WIDTH   (4),
    .LOAD_TIMEOUT   (10)
  ) u_dut (
    .LANE_SCHED_CLOCK_50 (clk),
    .LANE_SCHED_RESET    (rst),
    .sched_bus           (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk_val(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t rel=%0d)",
               tag, obs, exp, $time, rel);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected SHIFT_OUT given the burst period in clock cycles (0 = frozen).
  function automatic logic [3:0] exp_shift(input int r, input int pc);
    int off;
    if (pc == 0 || r < pc + 1) return 4'b0000;
    off = (r - pc - 1) % pc;
    if (off < 4) return 4'(1 << off);
    return 4'b0000;
  endfunction

  // Pulse CN_IN for one cycle; returns in the first LOAD_REQ cycle.
  task automatic start_load(input logic [1:0] lvl);
    u_if.LANE_SCHED_CN_IN  = 1'b1;
    u_if.LANE_SCHED_NVL_IN = lvl;
    step();
    u_if.LANE_SCHED_CN_IN  = 1'b0;
  endtask

  // Walks lanes first..3 from a LOAD_REQ cycle, acking 2 cycles after each
  // strobe. abort_lane: CN_IN with new_lvl coincides with that lane's ack,
  // return in the new LOAD_REQ cycle. mute_lane: no ack, return in its
  // first LOAD_WAIT cycle. Otherwise returns in the first RUN cycle.
  task automatic ack_lanes(input logic [1:0] lvl, input int first,
                           input int abort_lane, input logic [1:0] new_lvl,
                           input int mute_lane);
    for (int k = first; k < 4; k++) begin
      chk_val("load_req", 32'(u_if.LANE_SCHED_LOAD_OUT), 32'(1 << k));
      chk_val("busy_req", 32'(u_if.LANE_SCHED_BUSY_OUT), 32'd1);
      chk_val("level", 32'(u_if.LANE_SCHED_LEVEL_OUT), 32'(lvl));
      chk_val("shift_load", 32'(u_if.LANE_SCHED_SHIFT_OUT), 32'd0);
      step();
      if (k == mute_lane) return;
      chk_val("load_wait", 32'(u_if.LANE_SCHED_LOAD_OUT), 32'd0);
      chk_val("busy_wait", 32'(u_if.LANE_SCHED_BUSY_OUT), 32'd1);
      step();
      u_if.LANE_SCHED_LOADED_IN = 4'(1 << k);
      if (k == abort_lane) begin
        u_if.LANE_SCHED_CN_IN  = 1'b1;
        u_if.LANE_SCHED_NVL_IN = new_lvl;
      end
      step();
      u_if.LANE_SCHED_LOADED_IN = 4'b0000;
      if (k == abort_lane) begin
        u_if.LANE_SCHED_CN_IN = 1'b0;
        return;
      end
    end
    rel = 1;
    chk_val("busy_run", 32'(u_if.LANE_SCHED_BUSY_OUT), 32'd0);
    chk_val("load_run", 32'(u_if.LANE_SCHED_LOAD_OUT), 32'd0);
  endtask

  // Checks SHIFT_OUT each cycle up to and including cycle 'last'.
  task automatic run_check(input int pc, input int last);
    chk_val("shift", 32'(u_if.LANE_SCHED_SHIFT_OUT), 32'(exp_shift(rel, pc)));
    while (rel < last) begin
      step();
      rel++;
      chk_val("shift", 32'(u_if.LANE_SCHED_SHIFT_OUT),
              32'(exp_shift(rel, pc)));
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rel   = 0;
    rst   = 1'b1;
    u_if.LANE_SCHED_NVL_IN    = 2'd0;
    u_if.LANE_SCHED_CN_IN     = 1'b0;
    u_if.LANE_SCHED_LOADED_IN = 4'b0000;
    step();
    step();
    chk_val("rst_load", 32'(u_if.LANE_SCHED_LOAD_OUT), 32'd0);
    chk_val("rst_shift", 32'(u_if.LANE_SCHED_SHIFT_OUT), 32'd0);
    chk_val("rst_level", 32'(u_if.LANE_SCHED_LEVEL_OUT), 32'd0);
    chk_val("rst_busy", 32'(u_if.LANE_SCHED_BUSY_OUT), 32'd0);
    chk_val("rst_err", 32'(u_if.LANE_SCHED_ERR_OUT), 32'd0);
    rst = 1'b0;
    step();
    chk_val("idle_load", 32'(u_if.LANE_SCHED_LOAD_OUT), 32'd0);

    // Level 3: first shift 17 cycles after last ack, bursts every 16.
    start_load(2'd3);
    ack_lanes(2'd3, 0, -1, 2'd0, -1);
    run_check(16, 40);

    // Level 1: bursts every 32.
    start_load(2'd1);
    ack_lanes(2'd1, 0, -1, 2'd0, -1);
    run_check(32, 70);

    // Level 0: frozen for 200 cycles.
    start_load(2'd0);
    ack_lanes(2'd0, 0, -1, 2'd0, -1);
    run_check(0, 200);

    // Level change while lane 1 of a burst is shifting.
    start_load(2'd3);
    ack_lanes(2'd3, 0, -1, 2'd0, -1);
    run_check(16, 18);
    chk_val("mid_burst", 32'(u_if.LANE_SCHED_SHIFT_OUT), 32'b0010);
    start_load(2'd2);
    ack_lanes(2'd2, 0, -1, 2'd0, -1);
    run_check(24, 60);

    // CN_IN in the same cycle as the lane-2 ack: ack ignored, restart lane 0.
    start_load(2'd2);
    ack_lanes(2'd2, 0, 2, 2'd1, -1);
    ack_lanes(2'd1, 0, -1, 2'd0, -1);
    run_check(32, 40);

    // Lane 1 never acknowledges.
    start_load(2'd3);
    ack_lanes(2'd3, 0, -1, 2'd0, 1);
`ifdef LANE_SCHED_LOAD_TIMEOUT_EN
    for (int i = 0; i < 10; i++) begin
      chk_val("to_err_low", 32'(u_if.LANE_SCHED_ERR_OUT), 32'd0);
      chk_val("to_load_low", 32'(u_if.LANE_SCHED_LOAD_OUT), 32'd0);
      step();
    end
    chk_val("to_err_set", 32'(u_if.LANE_SCHED_ERR_OUT), 32'd1);
    ack_lanes(2'd3, 2, -1, 2'd0, -1);
    chk_val("to_err_sticky", 32'(u_if.LANE_SCHED_ERR_OUT), 32'd1);
    step();
    rst = 1'b1;
    #1;
    chk_val("arst_err", 32'(u_if.LANE_SCHED_ERR_OUT), 32'd0);
    chk_val("arst_level", 32'(u_if.LANE_SCHED_LEVEL_OUT), 32'd0);
`else
    for (int i = 0; i < 30; i++) begin
      chk_val("hang_err", 32'(u_if.LANE_SCHED_ERR_OUT), 32'd0);
      chk_val("hang_busy", 32'(u_if.LANE_SCHED_BUSY_OUT), 32'd1);
      chk_val("hang_load", 32'(u_if.LANE_SCHED_LOAD_OUT), 32'd0);
      step();
    end
    // Reset asserted mid-cycle while waiting: outputs clear without a clock.
    rst = 1'b1;
    #1;
    chk_val("arst_busy", 32'(u_if.LANE_SCHED_BUSY_OUT), 32'd0);
    chk_val("arst_level", 32'(u_if.LANE_SCHED_LEVEL_OUT), 32'd0);
`endif
    step();
    rst = 1'b0;
    step();
    chk_val("post_rst_busy", 32'(u_if.LANE_SCHED_BUSY_OUT), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
